// File: rtl/addend_packer_pkg.sv
// Shared definitions for the adder unit: packer FSM states and the lane-count width helper.
package addend_packer_pkg;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_SUM  = 2'd1,
      ST_HOLD = 2'd2
   } packer_state_e;

   // Bits needed to hold a lane count from 0 to length inclusive.
   function automatic int count_width(input int length);
      return $clog2(length + 1);
   endfunction

endpackage

// File: rtl/addend_packer_adder_tree.sv
// Balanced combinational adder tree: sign-extends LENGTH lanes to OUT_WIDTH and reduces them pairwise.
module AdderTree #(
   parameter int DATA_WIDTH = 32,
   parameter int LENGTH     = 8,
   parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH)
) (
   input  logic [LENGTH*DATA_WIDTH-1:0] data_i,
   output logic signed [OUT_WIDTH-1:0]  sum_o
);

   localparam int LEVELS = $clog2(LENGTH);
   localparam int NLEAF  = 1 << LEVELS;

   genvar gi, gj;
   generate
      for (gi = 0; gi <= LEVELS; gi++) begin : lvl_g
         localparam int N = NLEAF >> gi;
         logic signed [OUT_WIDTH-1:0] node [N];
         for (gj = 0; gj < N; gj++) begin : node_g
            if (gi == 0) begin : leaf_g
               // Leaves beyond LENGTH pad the tree to a power of two and contribute zero.
               if (gj < LENGTH) begin : used_g
                  assign node[gj] = OUT_WIDTH'(signed'(data_i[gj*DATA_WIDTH +: DATA_WIDTH]));
               end else begin : pad_g
                  assign node[gj] = '0;
               end
            end else begin : add_g
               assign node[gj] = lvl_g[gi-1].node[2*gj] + lvl_g[gi-1].node[2*gj+1];
            end
         end
      end
   endgenerate

   assign sum_o = lvl_g[LEVELS].node[0];

endmodule

// File: rtl/addend_packer.sv
// Collects up to LENGTH signed addends into lanes, sums them in one SUM cycle and holds the result
// until the consumer takes it.
module addend_packer
   import addend_packer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LENGTH     = 8,
   parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          out_sum,
   output logic [$clog2(LENGTH+1)-1:0]   out_count
);

   localparam int CW = count_width(LENGTH);

   packer_state_e                  state_q;
   logic [LENGTH*DATA_WIDTH-1:0]   lanes_q;
   logic [LENGTH*DATA_WIDTH-1:0]   lanes_d;
   logic [CW-1:0]                  idx_q;
   logic                           in_ready_q;
   logic                           out_valid_q;
   logic [OUT_WIDTH-1:0]           out_sum_q;
   logic [CW-1:0]                  out_count_q;
   logic signed [OUT_WIDTH-1:0]    tree_sum;
   logic                           accept;
   logic                           close_set;

   assign accept    = in_valid && in_ready_q;
   // A last-flagged addend in the final lane closes the set once, same as an unflagged one.
   assign close_set = accept && (in_last || (idx_q == CW'(LENGTH - 1)));

   genvar gi;
   generate
      for (gi = 0; gi < LENGTH; gi++) begin : lane_g
         assign lanes_d[gi*DATA_WIDTH +: DATA_WIDTH] =
            (accept && (idx_q == CW'(gi))) ? in_data : lanes_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   AdderTree #(
      .DATA_WIDTH (DATA_WIDTH),
      .LENGTH     (LENGTH),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_adder_tree (
      .data_i (lanes_q),
      .sum_o  (tree_sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         lanes_q     <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  lanes_q <= lanes_d;
                  idx_q   <= idx_q + CW'(1);
               end
               if (close_set) begin
                  state_q    <= ST_SUM;
                  in_ready_q <= 1'b0;
               end
            end
            ST_SUM: begin
               out_sum_q   <= tree_sum;
               out_count_q <= idx_q;
               out_valid_q <= 1'b1;
               state_q     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  lanes_q     <= '0;
                  idx_q       <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_FILL;
               end
            end
            default: begin
               state_q     <= ST_FILL;
               lanes_q     <= '0;
               idx_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_addend_packer.sv
// Directed bench for addend_packer at default parameters; expected sums are hand-computed constants.
module tb_addend_packer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_data;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic signed [34:0] out_sum;
   logic [3:0]         out_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   addend_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_count (out_count)
   );

   task automatic check_val(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one addend and return 1 ns after the edge that accepted it.
   task automatic send(input logic [31:0] d, input logic l);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check_val("send_timeout", 1, 0);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic signed [63:0] exp_sum,
                             input logic signed [63:0] exp_cnt);
      int guard = 0;
      while (!out_valid && guard < 50) begin
         tick();
         guard++;
      end
      check_val({tag, "_valid"}, out_valid, 1);
      check_val({tag, "_sum"}, out_sum, exp_sum);
      check_val({tag, "_count"}, out_count, exp_cnt);
      $display("result %s: sum=%0d count=%0d", tag, out_sum, out_count);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [34:0] held_sum;
      logic [3:0]         held_cnt;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      do_reset();

      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_sum", out_sum, 0);
      check_val("rst_out_count", out_count, 0);

      // 1..8 back-to-back, with latency check
      for (int k = 1; k <= 8; k++) send(32'(k), 1'b0);
      check_val("lat_sum_cycle_valid", out_valid, 0);
      check_val("lat_sum_cycle_ready", in_ready, 0);
      tick();
      check_val("lat_hold_valid", out_valid, 1);
      get_result("seq1to8", 36, 8);

      // Extremes
      for (int k = 0; k < 8; k++) send(32'h8000_0000, 1'b0);
      get_result("min8", -64'sd17179869184, 8);
      for (int k = 0; k < 8; k++) send(32'h7FFF_FFFF, 1'b0);
      get_result("max8", 64'sd17179869176, 8);

      // Early close and a single-addend set
      send(32'd5, 1'b0);
      send(-32'sd7, 1'b0);
      send(32'd10, 1'b1);
      get_result("early3", 8, 3);
      send(32'd42, 1'b1);
      get_result("single", 42, 1);

      // in_last on the final lane closes exactly once
      for (int k = 1; k <= 8; k++) send(32'(k), k == 8);
      get_result("last_on_lane7", 36, 8);
      for (int c = 0; c < 4; c++) tick();
      check_val("no_double_close", out_valid, 0);

      // Back-pressure in HOLD with in_valid asserted
      send(32'd7, 1'b0);
      send(32'd11, 1'b1);
      while (!out_valid) tick();
      held_sum = out_sum;
      held_cnt = out_count;
      check_val("hold_sum_initial", held_sum, 18);
      in_valid = 1'b1;
      in_data  = 32'd99;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_val("hold_sum_stable", out_sum, 18);
         check_val("hold_cnt_stable", out_count, 2);
         check_val("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_val("after_hs_in_ready", in_ready, 1);
      check_val("after_hs_out_valid", out_valid, 0);
      send(32'd3, 1'b1);
      get_result("after_hold", 3, 1);

      // Reset aborts a partial set
      for (int k = 0; k < 4; k++) send(32'd9, 1'b0);
      do_reset();
      check_val("abort_out_valid", out_valid, 0);
      check_val("abort_in_ready", in_ready, 1);
      for (int k = 0; k < 8; k++) send(32'd1, 1'b0);
      get_result("after_abort", 8, 8);

      // Reset while a result is pending
      send(32'd77, 1'b1);
      while (!out_valid) tick();
      do_reset();
      check_val("pending_discard_valid", out_valid, 0);
      check_val("pending_discard_sum", out_sum, 0);

      // Random gaps in in_valid
      for (int k = 1; k <= 8; k++) begin
         int gap = $urandom_range(0, 1);
         for (int g = 0; g < gap; g++) tick();
         send(32'(k), 1'b0);
      end
      get_result("gaps", 36, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
